// File: rtl/conversor_bcd_display_6bits.sv
// Binary (0..63) to two-digit BCD converter with 7-segment outputs.
// A sequential shift-and-add-3 engine runs six iterations per conversion.
// Conversions start on a start request, or on any change of bin when AUTO=1.
//
// Handshake: start is sampled on the rising edge and honoured only in IDLE or
// DONE. busy is high for the six SHIFT cycles. done pulses for one cycle, in
// the same cycle the new digits and segment codes first appear. A start seen
// while busy is dropped, not queued.
module conversor_bcd_display_6bits #(
    parameter bit SEG_ATIVO_BAIXO = 1'b0,
    parameter bit AUTO            = 1'b0
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [5:0] bin,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic [6:0] seg_dez,
    output logic [6:0] seg_uni,
    output logic [1:0] dbg_estado
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } estado_t;

    estado_t     estado;
    estado_t     estado_nxt;

    logic [5:0]  bin_sr;     // value being shifted out, MSB first
    logic [3:0]  bcd_dez;    // tens work digit
    logic [3:0]  bcd_uni;    // units work digit
    logic [2:0]  iter;       // completed iterations
    logic [5:0]  captura;    // bin as captured at the trigger edge
    logic [5:0]  ultimo;     // last value whose result is on the outputs

    logic        gatilho;
    logic        carregar;
    logic [3:0]  dez_cor;
    logic [3:0]  uni_cor;
    logic [13:0] desl;

    // Digit to segment code, gfedcba; an impossible digit blanks the display.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] raw;
        case (d)
            4'd0:    raw = 7'h3F;
            4'd1:    raw = 7'h06;
            4'd2:    raw = 7'h5B;
            4'd3:    raw = 7'h4F;
            4'd4:    raw = 7'h66;
            4'd5:    raw = 7'h6D;
            4'd6:    raw = 7'h7D;
            4'd7:    raw = 7'h07;
            4'd8:    raw = 7'h7F;
            4'd9:    raw = 7'h6F;
            default: raw = 7'h00;
        endcase
        return SEG_ATIVO_BAIXO ? ~raw : raw;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            estado <= S_IDLE;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Next state, trigger decode and one add-3/shift iteration of the engine.
    always_comb begin
        estado_nxt = estado;
        carregar   = 1'b0;
        gatilho    = start || (AUTO && (bin != ultimo));
        uni_cor    = (bcd_uni >= 4'd5) ? (bcd_uni + 4'd3) : bcd_uni;
        dez_cor    = (bcd_dez >= 4'd5) ? (bcd_dez + 4'd3) : bcd_dez;
        desl       = {dez_cor, uni_cor, bin_sr} << 1;
        case (estado)
            S_IDLE: begin
                if (gatilho) begin
                    carregar   = 1'b1;
                    estado_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (iter == 3'd5) begin
                    estado_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A pending trigger restarts immediately, so a held start
                // gives one conversion every seven cycles.
                if (gatilho) begin
                    carregar   = 1'b1;
                    estado_nxt = S_SHIFT;
                end else begin
                    estado_nxt = S_IDLE;
                end
            end
            default: begin
                estado_nxt = S_IDLE;
            end
        endcase
    end

    // Work registers and the result registers loaded on the final iteration.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            bin_sr  <= '0;
            bcd_dez <= '0;
            bcd_uni <= '0;
            iter    <= '0;
            captura <= '0;
            ultimo  <= '0;
            dezena  <= '0;
            unidade <= '0;
            seg_dez <= seg7(4'd0);
            seg_uni <= seg7(4'd0);
        end else begin
            if (carregar) begin
                bin_sr  <= bin;
                captura <= bin;
                bcd_dez <= '0;
                bcd_uni <= '0;
                iter    <= '0;
            end else if (estado == S_SHIFT) begin
                bin_sr  <= desl[5:0];
                bcd_uni <= desl[9:6];
                bcd_dez <= desl[13:10];
                iter    <= iter + 3'd1;
            end
            // The sixth iteration's result goes straight to the outputs so
            // that they are valid in the DONE cycle.
            if ((estado == S_SHIFT) && (iter == 3'd5)) begin
                dezena  <= desl[13:10];
                unidade <= desl[9:6];
                seg_dez <= seg7(desl[13:10]);
                seg_uni <= seg7(desl[9:6]);
                ultimo  <= captura;
            end
        end
    end

    assign busy       = (estado == S_SHIFT);
    assign done       = (estado == S_DONE);
    assign dbg_estado = estado;

endmodule

// File: tb/tb_conversor_bcd_display_6bits.sv
// Bench for conversor_bcd_display_6bits: three instances (plain, AUTO=1,
// active-low segments) compared every cycle against a timeline model.
module tb_conversor_bcd_display_6bits;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic RESET = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] bin = '0;
    logic       start = 1'b0;
    logic [5:0] bin_b = '0;
    logic       start_b = 1'b0;

    logic       busy_o    [3];
    logic       done_o    [3];
    logic [3:0] dez_o     [3];
    logic [3:0] uni_o     [3];
    logic [6:0] seg_dez_o [3];
    logic [6:0] seg_uni_o [3];
    logic [1:0] dbg_o     [3];

    conversor_bcd_display_6bits #(.SEG_ATIVO_BAIXO(1'b0), .AUTO(1'b0)) u_dut (
        .clk(clk), .RESET(RESET), .bin(bin), .start(start),
        .busy(busy_o[0]), .done(done_o[0]), .dezena(dez_o[0]), .unidade(uni_o[0]),
        .seg_dez(seg_dez_o[0]), .seg_uni(seg_uni_o[0]), .dbg_estado(dbg_o[0]));

    conversor_bcd_display_6bits #(.SEG_ATIVO_BAIXO(1'b0), .AUTO(1'b1)) u_auto (
        .clk(clk), .RESET(RESET), .bin(bin_b), .start(start_b),
        .busy(busy_o[1]), .done(done_o[1]), .dezena(dez_o[1]), .unidade(uni_o[1]),
        .seg_dez(seg_dez_o[1]), .seg_uni(seg_uni_o[1]), .dbg_estado(dbg_o[1]));

    conversor_bcd_display_6bits #(.SEG_ATIVO_BAIXO(1'b1), .AUTO(1'b0)) u_low (
        .clk(clk), .RESET(RESET), .bin(bin), .start(start),
        .busy(busy_o[2]), .done(done_o[2]), .dezena(dez_o[2]), .unidade(uni_o[2]),
        .seg_dez(seg_dez_o[2]), .seg_uni(seg_uni_o[2]), .dbg_estado(dbg_o[2]));

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int inst, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t",
                     name, inst, act, act, exp_v, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: a trigger accepted while free makes the result appear
    // six cycles later for one cycle; digits are plain division by ten.
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int m_rem  [3] = '{0, 0, 0};
    int m_cap  [3] = '{0, 0, 0};
    int m_last [3] = '{0, 0, 0};
    int m_dez  [3] = '{0, 0, 0};
    int m_uni  [3] = '{0, 0, 0};
    bit m_done [3] = '{0, 0, 0};
    int m_b;
    bit m_s;

    always @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 3; i++) begin
                m_rem[i] = 0; m_cap[i] = 0; m_last[i] = 0;
                m_dez[i] = 0; m_uni[i] = 0; m_done[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_b = (i == 1) ? int'(bin_b) : int'(bin);
                m_s = (i == 1) ? start_b : start;
                m_done[i] = 1'b0;
                if (m_rem[i] > 0) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_done[i] = 1'b1;
                        m_dez[i]  = m_cap[i] / 10;
                        m_uni[i]  = m_cap[i] % 10;
                        m_last[i] = m_cap[i];
                    end
                end else if (m_s || ((i == 1) && (m_b != m_last[i]))) begin
                    m_cap[i] = m_b;
                    m_rem[i] = 6;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [6:0] inv;
                inv = (i == 2) ? 7'h7F : 7'h00;
                check("busy", i, int'(busy_o[i]), int'(m_rem[i] > 0));
                check("done", i, int'(done_o[i]), int'(m_done[i]));
                check("dezena", i, int'(dez_o[i]), m_dez[i]);
                check("unidade", i, int'(uni_o[i]), m_uni[i]);
                check("seg_dez", i, int'(seg_dez_o[i]), int'(seg_tab[m_dez[i]] ^ inv));
                check("seg_uni", i, int'(seg_uni_o[i]), int'(seg_tab[m_uni[i]] ^ inv));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One start pulse on bin=v; returns at the negedge where done is seen.
    task automatic convert(input logic [5:0] v, input bit wiggle);
        int n_busy;
        int k;
        bit seen;
        n_busy = 0;
        k = 0;
        seen = 1'b0;
        bin = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen && (k < 20)) begin
            if (busy_o[0]) n_busy++;
            if (done_o[0]) begin
                seen = 1'b1;
            end else begin
                if (wiggle) bin = 6'($urandom_range(0, 63));
                @(negedge clk);
            end
            k++;
        end
        check("done_seen", 0, int'(seen), 1);
        check("busy_cycles", 0, n_busy, 6);
    endtask

    // ---------------- stimulus ----------------
    int ndone;
    int cyc;
    int last_c;
    int d_hold;
    int u_hold;
    logic [5:0] dir_vals [7] = '{6'd63, 6'd0, 6'd9, 6'd10, 6'd37, 6'd59, 6'd8};

    initial begin
        // Reset: low for two cycles, then release.
        RESET = 1'b0;
        repeat (2) @(negedge clk);
        RESET = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_dezena", 0, int'(dez_o[0]), 0);
        check("rst_unidade", 0, int'(uni_o[0]), 0);
        check("rst_seg_dez", 0, int'(seg_dez_o[0]), 'h3F);
        check("rst_seg_uni", 0, int'(seg_uni_o[0]), 'h3F);
        check("rst_busy", 0, int'(busy_o[0]), 0);
        check("rst_done", 0, int'(done_o[0]), 0);
        check("rst_seg_low", 2, int'(seg_dez_o[2]), 'h40);

        // Directed values, with literal pins on 63 and on 8 (active-low).
        for (int j = 0; j < 7; j++) begin
            convert(dir_vals[j], 1'b0);
            if (dir_vals[j] == 6'd63) begin
                check("pin63_dez", 0, int'(dez_o[0]), 6);
                check("pin63_uni", 0, int'(uni_o[0]), 3);
                check("pin63_seg_dez", 0, int'(seg_dez_o[0]), 'h7D);
                check("pin63_seg_uni", 0, int'(seg_uni_o[0]), 'h4F);
            end
            if (dir_vals[j] == 6'd8) begin
                check("pin8_low_seg_uni", 2, int'(seg_uni_o[2]), 'h00);
                check("pin8_low_seg_dez", 2, int'(seg_dez_o[2]), 'h40);
            end
            @(negedge clk);
        end

        // Random values; bin is scrambled while the engine runs.
        repeat (25) begin
            convert(6'($urandom_range(0, 63)), 1'b1);
            @(negedge clk);
        end

        // Handshake: a second start during busy is dropped.
        bin = 6'd37;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin = 6'd12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        d_hold = -1;
        u_hold = -1;
        repeat (15) begin
            if (done_o[0]) begin
                ndone++;
                d_hold = int'(dez_o[0]);
                u_hold = int'(uni_o[0]);
            end
            @(negedge clk);
        end
        check("hs_done_count", 0, ndone, 1);
        check("hs_dez", 0, d_hold, 3);
        check("hs_uni", 0, u_hold, 7);

        // Held start: back-to-back conversions seven cycles apart.
        start = 1'b1;
        ndone = 0;
        cyc = 0;
        last_c = -1;
        d_hold = -1;
        while ((ndone < 2) && (cyc < 30)) begin
            bin = 6'($urandom_range(0, 63));
            @(negedge clk);
            cyc++;
            if (done_o[0]) begin
                ndone++;
                if (last_c >= 0) d_hold = cyc - last_c;
                last_c = cyc;
            end
        end
        start = 1'b0;
        check("held_gap", 0, d_hold, 7);
        repeat (10) @(negedge clk);

        // Reset in the middle of a conversion of 45.
        bin = 6'd45;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 RESET = 1'b0;
        #1;
        check("midrst_busy", 0, int'(busy_o[0]), 0);
        check("midrst_done", 0, int'(done_o[0]), 0);
        check("midrst_dez", 0, int'(dez_o[0]), 0);
        check("midrst_uni", 0, int'(uni_o[0]), 0);
        check("midrst_seg_uni", 0, int'(seg_uni_o[0]), 'h3F);
        @(negedge clk);
        RESET = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o[0]) ndone++;
        end
        check("midrst_no_done", 0, ndone, 0);
        convert(6'd45, 1'b0);
        check("after_rst_dez", 0, int'(dez_o[0]), 4);
        check("after_rst_uni", 0, int'(uni_o[0]), 5);
        @(negedge clk);

        // AUTO instance fed by a down-counter stepping every cycle from 63.
        ndone = 0;
        cyc = 0;
        last_c = -1;
        bin_b = 6'd63;
        repeat (90) begin
            @(negedge clk);
            cyc++;
            if (done_o[1]) begin
                ndone++;
                if (last_c >= 0) check("auto_gap", 1, cyc - last_c, 7);
                if (ndone == 1) begin
                    check("auto_first_dez", 1, int'(dez_o[1]), 6);
                    check("auto_first_uni", 1, int'(uni_o[1]), 3);
                end
                last_c = cyc;
            end
            if (bin_b != 6'd0) bin_b = bin_b - 6'd1;
        end
        check("auto_count", 1, ndone, 10);
        check("auto_last_dez", 1, int'(dez_o[1]), 0);
        check("auto_last_uni", 1, int'(uni_o[1]), 0);
        check("auto_idle", 1, int'(busy_o[1]), 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
